// File: rtl/uart_tx_io_if.sv
// IO-page bus seen by the UART transmitter: word selects, strobes, data and the TX pin.
// master = processor/decoder side, slave = UART side.
// Read data is registered inside the slave; no combinational return path.
interface uart_tx_io_if;
  logic        sel_data;
  logic        sel_status;
  logic        io_wstrb;
  logic        io_rstrb;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        tx;

  modport master (
    output sel_data, sel_status, io_wstrb, io_rstrb, io_wdata,
    input  io_rdata, tx
  );

  modport slave (
    input  sel_data, sel_status, io_wstrb, io_rstrb, io_wdata,
    output io_rdata, tx
  );
endinterface

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by IO stores, STATUS readable by firmware.
// Latency: io_rdata 1 cycle after io_rstrb; tx falls 2 cycles after a DATA store into an idle, empty UART.
// Backpressure: none on the bus; a store to a full FIFO with no pop that cycle is dropped and sets sticky overflow.
module uart_tx_io #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  uart_tx_io_if.slave bus
);

  // CLKS_PER_BIT must be at least 2 and FIFO_DEPTH a power of two >= 2.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  // Serialiser
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  // Bus return
  logic [31:0]   r_rdata;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_drop;
  logic w_ovf_clr;
  logic w_busy;
  logic w_baud_done;
  logic w_unused;

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  // The serialiser takes a byte only from IDLE, so a pop can free a slot for a same-cycle push.
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_push_req  = bus.io_wstrb & bus.sel_data;
  assign w_push      = w_push_req & (!w_full | w_pop);
  assign w_drop      = w_push_req & w_full & !w_pop;
  assign w_ovf_clr   = bus.io_wstrb & bus.sel_status & bus.io_wdata[2];
  assign w_busy      = (r_state != S_IDLE) | !w_empty;
  assign w_baud_done = (r_baud == BAUD_LAST);

  // Only the low byte (DATA) and bit 2 (STATUS) of the store data carry meaning.
  assign w_unused = &{1'b0, bus.io_wdata[31:8]};

  assign bus.tx       = r_tx;
  assign bus.io_rdata = r_rdata;

  // Byte storage; written only when the store is accepted so a dropped byte cannot clobber the oldest entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.io_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Registered read port: updates only on a read strobe, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (bus.io_rstrb) begin
      if (bus.sel_status) begin
        r_rdata <= {29'd0, r_ovf, w_full, w_busy};
      end else begin
        r_rdata <= '0;
      end
    end
  end

  // 8N1 serialiser; tx is registered and set alongside each state change so it lines up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // LSB first: the next bit on the line is the one about to become shift[0].
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_baud  <= '0;
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Self-checking bench for uart_tx_io at 4 clocks per bit, FIFO depth 4.
// A frame-level model predicts tx and io_rdata every cycle; directed scenarios add literal checks.
module tb_uart_tx_io;
  localparam int CLK_FREQ = 12000000;
  localparam int BAUD     = 3000000;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;
  localparam int HN       = 16384;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_tx_io_if bus();

  uart_tx_io #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_model_prints = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  logic        tx_hist [HN];
  logic [31:0] rd_hist [HN];
  logic [7:0]  dec_b [$];
  int          dec_s [$];

  // Behavioural model: a byte queue plus "frame in flight since cycle pos".
  logic [7:0]  m_q [$];
  logic        m_ovf = 1'b0;
  logic        m_active = 1'b0;
  int          m_pos = 0;
  logic [7:0]  m_byte = 8'h00;
  logic [31:0] m_rdata = 32'd0;
  logic        m_tx = 1'b1;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic model_step();
    logic busy, full, pop, drop;
    logic [7:0] b;
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_active = 1'b0;
      m_pos = 0;
      m_rdata = 32'd0;
      m_tx = 1'b1;
    end else begin
      busy = m_active || (m_q.size() != 0);
      full = (m_q.size() == DEPTH);
      pop  = !m_active && (m_q.size() != 0);
      if (bus.io_rstrb) m_rdata = bus.sel_status ? {29'd0, m_ovf, full, busy} : 32'd0;
      b = 8'h00;
      if (pop) b = m_q.pop_front();
      drop = 1'b0;
      if (bus.io_wstrb && bus.sel_data) begin
        if (full && !pop) drop = 1'b1;
        else m_q.push_back(bus.io_wdata[7:0]);
      end
      if (drop) m_ovf = 1'b1;
      else if (bus.io_wstrb && bus.sel_status && bus.io_wdata[2]) m_ovf = 1'b0;
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end
      if (pop) begin
        m_active = 1'b1;
        m_pos = 0;
        m_byte = b;
      end
      m_tx = m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (cyc < HN) begin
      tx_hist[cyc] = bus.tx;
      rd_hist[cyc] = bus.io_rdata;
    end
    if (chk_en) begin
      n_tests++;
      if (bus.tx !== m_tx) begin
        n_fail++;
        if (n_model_prints < 20) $display("FAIL model_tx cyc=%0d got=%b exp=%b", cyc, bus.tx, m_tx);
        n_model_prints++;
      end
      n_tests++;
      if (bus.io_rdata !== m_rdata) begin
        n_fail++;
        if (n_model_prints < 20) $display("FAIL model_rdata cyc=%0d got=0x%0h exp=0x%0h", cyc, bus.io_rdata, m_rdata);
        n_model_prints++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic r,
                       input logic sd, input logic ss, input logic [31:0] wd);
    @(negedge clk);
    reset          = rst;
    bus.io_wstrb   = w;
    bus.io_rstrb   = r;
    bus.sel_data   = sd;
    bus.sel_status = ss;
    bus.io_wdata   = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic write_data(input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {24'd0, d});
  endtask

  task automatic read_req();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic read_status(output logic [31:0] v);
    int idx;
    read_req();
    idx = cyc;
    idle(2);
    v = rd_hist[idx+1];
  endtask

  // Recover frames from the recorded line by sampling mid-bit after each falling edge.
  task automatic decode(input int from, input int to);
    int c;
    logic [7:0] b;
    dec_b.delete();
    dec_s.delete();
    c = (from < 1) ? 1 : from + 1;
    while (c <= to && c + FRAME < HN) begin
      if (tx_hist[c-1] === 1'b1 && tx_hist[c] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = tx_hist[c + CPB*(k+1) + CPB/2];
        dec_b.push_back(b);
        dec_s.push_back(c);
        c += FRAME;
      end else begin
        c++;
      end
    end
  endtask

  initial begin
    int s;
    int w0;
    logic [31:0] v;
    logic [7:0] lit;
    logic [3:0] slot;
    logic       ebit;

    bus.io_wstrb = 1'b0;
    bus.io_rstrb = 1'b0;
    bus.sel_data = 1'b0;
    bus.sel_status = 1'b0;
    bus.io_wdata = 32'd0;

    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_en = 1'b1;
    idle(5);

    // Reset / idle
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_rdata", bus.io_rdata, 32'd0);
    read_status(v);
    check("reset_status", v, 32'd0);

    // Single 0xA5 frame with continuous STATUS polling
    idle(2);
    write_data(8'hA5);
    s = cyc;
    repeat (46) read_req();
    idle(4);
    check("a5_pre_idle", 32'(tx_hist[s+1]), 32'd1);
    lit = 8'hA5;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) slot[j] = tx_hist[s + 2 + 4*k + j];
      ebit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : lit[k-1];
      check($sformatf("a5_slot%0d", k), 32'(slot), ebit ? 32'hF : 32'h0);
    end
    check("a5_after_stop", 32'(tx_hist[s+42]), 32'd1);
    check("a5_busy_start", rd_hist[s+3], 32'd1);
    check("a5_busy_last_stop", rd_hist[s+42], 32'd1);
    check("a5_not_busy_after", rd_hist[s+43], 32'd0);

    // Six back-to-back writes into a depth-4 FIFO
    idle(2);
    for (int i = 0; i < 6; i++) begin
      write_data(8'(i + 1));
      if (i == 0) w0 = cyc;
    end
    read_req();
    idle(240);
    check("ovf_status", rd_hist[w0+7], 32'h7);
    decode(w0, cyc - 1);
    check("ovf_frames", 32'(dec_b.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < dec_b.size()) check($sformatf("ovf_byte%0d", i), 32'(dec_b[i]), 32'(i + 1));
    if (dec_s.size() > 0) check("ovf_first_start", 32'(dec_s[0] - w0), 32'd2);
    for (int i = 1; i < 5; i++)
      if (i < dec_s.size()) check($sformatf("ovf_spacing%0d", i), 32'(dec_s[i] - dec_s[i-1]), 32'd41);
    read_status(v);
    check("ovf_sticky", v, 32'h4);

    // Overflow clear through STATUS bit 2 only
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    read_status(v);
    check("ovf_kept_on_0", v, 32'h4);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4);
    read_status(v);
    check("ovf_cleared", v, 32'h0);

    // Push into a full FIFO on the same cycle the serialiser pops
    idle(2);
    for (int i = 0; i < 5; i++) begin
      write_data(8'(8'h10 + i));
      if (i == 0) w0 = cyc;
    end
    for (int i = 5; i <= 41; i++) begin
      if (i == 41) read_req();
      else idle(1);
    end
    write_data(8'h77);
    read_req();
    idle(300);
    check("fullpop_pre", rd_hist[w0+42], 32'h3);
    check("fullpop_post", rd_hist[w0+44], 32'h3);
    decode(w0, cyc - 1);
    check("fullpop_frames", 32'(dec_b.size()), 32'd6);
    for (int i = 0; i < 5; i++)
      if (i < dec_b.size()) check($sformatf("fullpop_byte%0d", i), 32'(dec_b[i]), 32'(8'h10 + i));
    if (dec_b.size() == 6) check("fullpop_last", 32'(dec_b[5]), 32'h77);

    // Reset during data bit 3 (0x35 has bit3 = 0), with a second byte queued
    idle(2);
    write_data(8'h35);
    s = cyc;
    write_data(8'h66);
    idle(17);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    read_req();
    idle(80);
    check("rst_bit3_low", 32'(tx_hist[s+19]), 32'd0);
    check("rst_tx_high", 32'(tx_hist[s+20]), 32'd1);
    check("rst_status", rd_hist[s+21], 32'd0);
    decode(s + 20, cyc - 1);
    check("rst_no_frames", 32'(dec_b.size()), 32'd0);
    write_data(8'h5A);
    w0 = cyc;
    idle(50);
    decode(w0, cyc - 1);
    check("rst_new_frames", 32'(dec_b.size()), 32'd1);
    if (dec_b.size() == 1) begin
      check("rst_new_byte", 32'(dec_b[0]), 32'h5A);
      check("rst_new_start", 32'(dec_s[0] - w0), 32'd2);
    end

    // Randomised traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic rst;
      logic ss;
      r   = $urandom_range(0, 99);
      rst = ($urandom_range(0, 599) == 0);
      ss  = 1'($urandom_range(0, 1));
      if (r < 8)       drive(rst, 1'b1, 1'b0, 1'b1, 1'b0, $urandom);
      else if (r < 11) drive(rst, 1'b1, 1'b0, 1'b0, 1'b1, $urandom);
      else if (r < 40) drive(rst, 1'b0, 1'b1, ~ss, ss, $urandom);
      else             drive(rst, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    end
    idle(FRAME * 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
